// File: rtl/riscv_mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port memory, one transaction at a time.
// Define ARB_STARVE_GUARD_EN to let a pending fetch win after MAX_WAIT consecutive data grants.
module riscv_mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iMemRead,
  input  logic [XLEN-1:0] iAddress,
  output logic [XLEN-1:0] iReadData,
  output logic            iReady,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] dAddress,
  input  logic [XLEN-1:0] dWriteData,
  output logic [XLEN-1:0] dReadData,
  output logic            dReady,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;  // 1 = data port owns the transaction
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] i_rdata_q, i_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            i_ready_q, i_ready_d;
  logic            d_ready_q, d_ready_d;
  logic            d_req_s;
  logic            grant_fetch_s;

  assign d_req_s = MemRead | MemWrite;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  // Fetch wins when data is idle or data has already taken MAX_WAIT grants in a row.
  always_comb begin
    grant_fetch_s = iMemRead & (~d_req_s | (starve_cnt_q == CW'(MAX_WAIT)));
  end

  // Starvation counter only moves on arbitration cycles.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE) begin
      if (!iMemRead || grant_fetch_s) begin
        starve_cnt_d = '0;
      end else if (d_req_s && (starve_cnt_q != CW'(MAX_WAIT))) begin
        starve_cnt_d = starve_cnt_q + CW'(1);
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Strict data priority.
  always_comb begin
    grant_fetch_s = iMemRead & ~d_req_s;
  end
`endif

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_fetch_s) begin
          owner_d     = 1'b0;
          mem_addr_d  = iAddress;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          mem_req_d   = 1'b1;
          state_d     = ISSUE;
        end else if (d_req_s) begin
          // MemRead together with MemWrite is treated as a store.
          owner_d     = 1'b1;
          mem_addr_d  = dAddress;
          mem_we_d    = MemWrite;
          mem_wdata_d = dWriteData;
          mem_req_d   = 1'b1;
          state_d     = ISSUE;
        end else begin
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
        end else begin
          mem_req_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_d = DONE;
          if (owner_q) begin
            d_ready_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else begin
          state_d = RESP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FSM and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign iReadData = i_rdata_q;
  assign dReadData = d_rdata_q;
  assign iReady    = i_ready_q;
  assign dReady    = d_ready_q;

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one unified single-port memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Arbitrates between the two ports and issues the winning request with a req/gnt handshake.
- Waits for the memory response and returns it to the owning port with a one-cycle ready pulse.
- The pipeline stalls a stage while its request is high and its ready is low. One transaction is outstanding at a time.

Parameters:
XLEN, 32, data/address width (matches RISCV_XLEN)
MAX_WAIT, 4, consecutive data grants allowed while fetch is pending (used only with ARB_STARVE_GUARD_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
iMemRead  in  1  fetch request; held stable until iReady
iAddress  in  XLEN  fetch address
iReadData  out  XLEN  fetched instruction word
iReady  out  1  one-cycle completion pulse for fetch
MemRead  in  1  load request; held until dReady
MemWrite  in  1  store request; held until dReady
dAddress  in  XLEN  load/store address
dWriteData  in  XLEN  store data
dReadData  out  XLEN  load data
dReady  out  1  one-cycle completion pulse for load/store
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  XLEN  memory address
mem_wdata  out  XLEN  memory write data
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid / write acknowledge
mem_rdata  in  XLEN  memory read data

Behaviour:
- Reset (rst=0, at any time including mid-transaction):
  - FSM goes to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, iReady, dReady, iReadData, dReadData and the starvation counter all go to 0.
  - Any in-flight memory transaction is abandoned.
- FSM states: IDLE, ISSUE, RESP, DONE.
- IDLE:
  - If MemRead|MemWrite is high, grant data. Otherwise, if iMemRead is high, grant fetch.
  - On grant: register owner, address, wdata and we (we = MemWrite). Go to ISSUE.
  - If MemRead and MemWrite are both high, it is a write.
- ISSUE:
  - mem_req=1; mem_addr, mem_we, mem_wdata come from the registered values and are stable until gnt.
  - On mem_gnt: go to RESP. mem_req drops on the following cycle.
- RESP:
  - mem_req=0. Wait any number of cycles for mem_rvalid.
  - mem_rvalid is ignored outside RESP, including in the same cycle as gnt.
  - On mem_rvalid: capture mem_rdata into the owner's ReadData register, only for reads. Go to DONE.
  - For a write, dReadData is unchanged.
- DONE:
  - Owner's ready = 1 for exactly this cycle. No arbitration in this cycle.
  - The requester still holds its request here; it must not be regranted.
  - Next state: IDLE.
- Best-case latency: request high in cycle 0, mem_req in cycle 1 (gnt same cycle), rvalid in cycle 2, ready in cycle 3, IDLE in cycle 4.
- Ready and ReadData are registered outputs. ReadData holds its value until the next read completion on that port.
- A request dropped before its grant is never issued.
- Address and data are not checked for alignment; the values are passed through unchanged.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments on each data grant made while iMemRead is high.
  - The counter clears on a fetch grant, or when iMemRead is low at an arbitration.
  - When the counter equals MAX_WAIT, the next arbitration with iMemRead high grants fetch even if data is requesting.
  - The counter saturates at MAX_WAIT.
- Not defined: strict data priority. No counter logic is present.

Test Plan:
- Reset mid-op: enter RESP, drive rst=0 -> same cycle all outputs 0; after release, with no requests, mem_req stays 0.
- Lone fetch: iAddress=0x100, mem_gnt=1 in cycle 1, mem_rvalid=1/mem_rdata=0xDEADBEEF in cycle 2 -> iReady=1 only in cycle 3, iReadData=0xDEADBEEF, dReady stays 0.
- Contention: iMemRead(0x200) and MemWrite(dAddress=0x400, dWriteData=0x55) asserted together:
  - First issue: mem_we=1, addr 0x400, wdata 0x55; dReady pulses.
  - Second issue: mem_we=0, addr 0x200; iReady pulses.
- Delayed grant: mem_gnt held low 3 cycles -> mem_req=1 with mem_addr constant for 4 cycles, no ready. Then gnt -> RESP.
- Illegal both: MemRead=MemWrite=1, dAddress=0x40 -> mem_we=1. After completion, dReadData is unchanged.
- Starvation guard: data port requests back-to-back with iMemRead held, MAX_WAIT=4:
  - With ARB_STARVE_GUARD_EN: fetch is granted as the 5th transaction.
  - Without it: no fetch grant while data requests persist.
